ps2_key_sequencer: RTL and testbench
====================================

PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, 200000, dspclk cycles allowed between prefix byte and its follow-up byte (2 ms at 100 MHz).
REQ-002 Parameter FIFO_DEPTH, 4, event queue depth; power of two, 2..16.
REQ-003 dspclk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 rx_valid  in  1  one-cycle strobe: received PS/2 byte available from the hid_controller receiver.
REQ-006 rx_data  in  8  received byte; qualified by rx_valid.
REQ-007 rx_pari_err  in  1  parity error flag for the byte; qualified by rx_valid.
REQ-008 evt_valid  out  1  event queue not empty.
REQ-009 evt_ready  in  1  consumer accepts the head event when high with evt_valid.
REQ-010 evt_code  out  8  head event scan code.
REQ-011 evt_break  out  1  head event is a release (1) or a press (0).
REQ-012 evt_ext  out  1  head event carried the E0 prefix.
REQ-013 led  out  8  code of the key currently shown as held.
REQ-014 err  out  1  sticky protocol error flag.
REQ-015 overflow  out  1  sticky event-drop flag.
REQ-016 clr  in  1  synchronous clear of err and overflow.

Function
REQ-017 FSM states SHALL be IDLE, EXT, BRK, EXT_BRK; a byte is consumed only on rx_valid=1 with rx_pari_err=0.
REQ-018 IDLE: E0 -> EXT; F0 -> BRK; 00 or FF -> set err, stay; any other byte -> push make {ext=0}, stay.
REQ-019 EXT: F0 -> EXT_BRK; E0 -> stay EXT; 00/FF -> set err, IDLE; other -> push make {ext=1}, IDLE.
REQ-020 BRK: E0/F0/00/FF -> set err, IDLE; other -> push break {ext=0}, IDLE.
REQ-021 EXT_BRK: E0/F0/00/FF -> set err, IDLE; other -> push break {ext=1}, IDLE.
REQ-022 rx_valid with rx_pari_err=1 SHALL discard the byte, set err, force IDLE, in any state.
REQ-023 Timeout counter SHALL reset on every rx_valid and count while not IDLE; reaching TIMEOUT_CYC forces IDLE and sets err.
REQ-024 Push SHALL occur on the edge sampling rx_valid; evt_valid SHALL be high in the following cycle when the queue was empty (1-cycle latency).
REQ-025 Pop occurs on an edge with evt_valid and evt_ready both high; evt_* outputs SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-026 Push to a full queue without simultaneous pop SHALL be dropped and set overflow; push and pop on the same edge when full SHALL both succeed.
REQ-027 led SHALL load evt code on every pushed make; SHALL clear to 00 on a pushed break whose code equals led.
REQ-028 clr SHALL clear err and overflow; a same-edge set event SHALL win over clr.

Reset
REQ-029 While reset is low: FSM=IDLE, queue empty, timeout counter=0, evt_valid=0, evt_code=00, evt_break=0, evt_ext=0, led=00, err=0, overflow=0.
REQ-030 Reset asserted mid-sequence SHALL discard any pending prefix and all queued events; deassertion is synchronised to dspclk.

Configuration
REQ-031 Macro PS2_TYPEMATIC_FILTER_EN defined: a make identical in {ext,code} to the last make, with no intervening matching break, SHALL not be pushed.
REQ-032 Macro undefined: every make SHALL be pushed, including typematic repeats; no held-key register is built.

Structure
REQ-033 Shared package ps2_pkg SHALL hold prefix constants (E0, F0), error codes (00, FF), FSM state encoding and the 10-bit event type {ext, break, code}.
REQ-034 Event queue SHALL be a separate sub-module ps2_evt_fifo (synchronous FIFO, registered storage, full/empty flags).

Verification
REQ-035 Reset low 100 ns then high -> all outputs 0, evt_valid=0.
REQ-036 Bytes 1C; then F0,1C with evt_ready=1 -> events {0,0,1C} then {0,1,1C}; led 1C then 00.
REQ-037 Bytes E0,75; then E0,F0,75 -> events {1,0,75} then {1,1,75}; err=0.
REQ-038 Byte F0 then idle TIMEOUT_CYC cycles -> err=1, FSM IDLE; next byte 1C -> make {0,0,1C}; clr -> err=0.
REQ-039 evt_ready=0, five distinct makes -> four queued in order, overflow=1; byte 1C with rx_pari_err=1 -> no event, err=1.
REQ-040 Bytes 1C,1C,1C -> one event with PS2_TYPEMATIC_FILTER_EN, three without.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event type for the PS/2 key sequencer.
package ps2_pkg;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_BRK = 8'hF0;
    localparam logic [7:0] ERR_LO  = 8'h00;
    localparam logic [7:0] ERR_HI  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } evt_t;

    function automatic logic is_err_code(input logic [7:0] b);
        return (b == ERR_LO) || (b == ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous event FIFO with registered storage; a push to a full queue
// succeeds only when a pop happens on the same edge.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  evt_t din,
    input  logic pop,
    output evt_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    evt_t            mem_q [DEPTH];
    evt_t            mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero when empty so the consumer never sees stale events.
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: decodes E0/F0 prefixes into make/break events.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated makes of a held key.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 200000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       dspclk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_pari_err,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic [7:0] led,
    output logic       err,
    output logic       overflow,
    input  logic       clr
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Async assert, dspclk-synchronised release of the internal reset.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge dspclk or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= rst_sync_d;
    end

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d, ovf_q, ovf_d;
    logic [7:0]    led_q, led_d;
    logic          err_set, push_req, push, fifo_full, fifo_empty, pop;
    evt_t          push_evt, head;

    always_comb begin
        state_d  = state_q;
        tmo_d    = tmo_q;
        err_set  = 1'b0;
        push_req = 1'b0;
        push_evt = '0;
        if (rx_valid) begin
            tmo_d = '0;
            if (rx_pari_err) begin
                err_set = 1'b1;
                state_d = IDLE;
            end else begin
                push_evt.code = rx_data;
                case (state_q)
                    IDLE: begin
                        if (rx_data == PFX_EXT)      state_d = EXT;
                        else if (rx_data == PFX_BRK) state_d = BRK;
                        else if (is_err_code(rx_data)) err_set = 1'b1;
                        else push_req = 1'b1;
                    end
                    EXT: begin
                        if (rx_data == PFX_BRK)      state_d = EXT_BRK;
                        else if (rx_data == PFX_EXT) state_d = EXT;
                        else begin
                            state_d = IDLE;
                            if (is_err_code(rx_data)) err_set = 1'b1;
                            else begin
                                push_req     = 1'b1;
                                push_evt.ext = 1'b1;
                            end
                        end
                    end
                    BRK, EXT_BRK: begin
                        state_d = IDLE;
                        if (is_err_code(rx_data) || rx_data == PFX_EXT || rx_data == PFX_BRK)
                            err_set = 1'b1;
                        else begin
                            push_req     = 1'b1;
                            push_evt.brk = 1'b1;
                            push_evt.ext = (state_q == EXT_BRK);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d = IDLE;
                err_set = 1'b1;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       last_vld_q, last_vld_d;
    logic [8:0] last_q, last_d;
    logic       dup;

    assign dup  = last_vld_q && !push_evt.brk && (last_q == {push_evt.ext, push_evt.code});
    assign push = push_req && !dup;

    always_comb begin
        last_vld_d = last_vld_q;
        last_d     = last_q;
        if (push && !push_evt.brk) begin
            last_vld_d = 1'b1;
            last_d     = {push_evt.ext, push_evt.code};
        end else if (push && push_evt.brk && last_q == {push_evt.ext, push_evt.code}) begin
            last_vld_d = 1'b0;
        end
    end

    always_ff @(posedge dspclk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld_q <= 1'b0;
            last_q     <= '0;
        end else begin
            last_vld_q <= last_vld_d;
            last_q     <= last_d;
        end
    end
`else
    assign push = push_req;
`endif

    assign pop = !fifo_empty && evt_ready;

    always_comb begin
        led_d = led_q;
        if (push && !push_evt.brk)                       led_d = push_evt.code;
        else if (push && push_evt.brk && push_evt.code == led_q) led_d = 8'h00;
        err_d = clr ? 1'b0 : err_q;
        if (err_set) err_d = 1'b1;
        ovf_d = clr ? 1'b0 : ovf_q;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge dspclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            led_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
        end
    end

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (dspclk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_evt),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head.code;
    assign evt_break = head.brk;
    assign evt_ext   = head.ext;
    assign led       = led_q;
    assign err       = err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed self-checking bench for ps2_key_sequencer (short timeout, depth-4 queue).
module tb_ps2_key_sequencer;

    localparam int TO = 20;

    logic       dspclk = 1'b0;
    logic       reset;
    logic       rx_valid, rx_pari_err, evt_ready, clr;
    logic [7:0] rx_data;
    logic       evt_valid, evt_break, evt_ext, err, overflow;
    logic [7:0] evt_code, led;

    int checks = 0;
    int errors = 0;

    ps2_key_sequencer #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(4)) dut (
        .dspclk      (dspclk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_pari_err (rx_pari_err),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .evt_break   (evt_break),
        .evt_ext     (evt_ext),
        .led         (led),
        .err         (err),
        .overflow    (overflow),
        .clr         (clr)
    );

    always #5 dspclk = ~dspclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; byte is sampled on the next posedge.
    task automatic send(input logic [7:0] b, input logic perr = 1'b0);
        rx_valid    = 1'b1;
        rx_data     = b;
        rx_pari_err = perr;
        @(negedge dspclk);
        rx_valid    = 1'b0;
        rx_pari_err = 1'b0;
    endtask

    task automatic expect_evt(input string tag, input logic ext, input logic brk, input logic [7:0] code);
        chk({tag, ".valid"}, evt_valid, 1'b1);
        chk({tag, ".code"},  evt_code,  code);
        chk({tag, ".break"}, evt_break, brk);
        chk({tag, ".ext"},   evt_ext,   ext);
        evt_ready = 1'b1;
        @(negedge dspclk);
        evt_ready = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge dspclk);
        clr = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_pari_err = 1'b0;
        evt_ready = 1'b0; clr = 1'b0;
        #50;
        chk("rst.valid", evt_valid, 1'b0);
        chk("rst.code",  evt_code,  8'h00);
        chk("rst.break", evt_break, 1'b0);
        chk("rst.ext",   evt_ext,   1'b0);
        chk("rst.led",   led,       8'h00);
        chk("rst.err",   err,       1'b0);
        chk("rst.ovf",   overflow,  1'b0);
        #50;
        @(negedge dspclk); reset = 1'b1;
        repeat (3) @(negedge dspclk);
        chk("post_rst.valid", evt_valid, 1'b0);

        // Plain make then break, one-cycle latency
        send(8'h1C);
        chk("mk1C.latency", evt_valid, 1'b1);
        chk("mk1C.led", led, 8'h1C);
        expect_evt("mk1C", 1'b0, 1'b0, 8'h1C);
        chk("mk1C.drained", evt_valid, 1'b0);
        send(8'hF0);
        chk("F0.noevt", evt_valid, 1'b0);
        send(8'h1C);
        expect_evt("brk1C", 1'b0, 1'b1, 8'h1C);
        chk("brk1C.led", led, 8'h00);

        // Extended make/break
        send(8'hE0); send(8'h75);
        expect_evt("emk75", 1'b1, 1'b0, 8'h75);
        chk("emk75.led", led, 8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_evt("ebrk75", 1'b1, 1'b1, 8'h75);
        chk("ebrk75.led", led, 8'h00);
        chk("ext.err", err, 1'b0);

        // Head holds while not ready
        send(8'h2B);
        repeat (3) @(negedge dspclk);
        expect_evt("hold2B", 1'b0, 1'b0, 8'h2B);

        // Prefix timeout boundary
        send(8'hF0);
        repeat (TO - 2) @(negedge dspclk);
        chk("tmo.early", err, 1'b0);
        repeat (4) @(negedge dspclk);
        chk("tmo.err", err, 1'b1);
        send(8'h1C);
        expect_evt("tmo.mk1C", 1'b0, 1'b0, 8'h1C);
        do_clr();
        chk("clr.err", err, 1'b0);

        // Set wins over clr on the same edge
        clr = 1'b1;
        send(8'h00);
        clr = 1'b0;
        chk("setwins.err", err, 1'b1);
        do_clr();
        chk("clr2.err", err, 1'b0);

        // Overflow: five makes into a depth-4 queue
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("full.noovf", overflow, 1'b0);
        send(8'h55);
        chk("ovf.set", overflow, 1'b1);
        expect_evt("q0", 1'b0, 1'b0, 8'h11);
        expect_evt("q1", 1'b0, 1'b0, 8'h22);
        expect_evt("q2", 1'b0, 1'b0, 8'h33);
        expect_evt("q3", 1'b0, 1'b0, 8'h44);
        chk("q.empty", evt_valid, 1'b0);
        do_clr();
        chk("clr.ovf", overflow, 1'b0);

        // Push and pop on the same edge while full
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        evt_ready = 1'b1;
        send(8'h65);
        evt_ready = 1'b0;
        chk("pp.noovf", overflow, 1'b0);
        expect_evt("pp0", 1'b0, 1'b0, 8'h62);
        expect_evt("pp1", 1'b0, 1'b0, 8'h63);
        expect_evt("pp2", 1'b0, 1'b0, 8'h64);
        expect_evt("pp3", 1'b0, 1'b0, 8'h65);

        // Parity error discards byte and drops a pending prefix
        send(8'h1C, 1'b1);
        chk("par.noevt", evt_valid, 1'b0);
        chk("par.err", err, 1'b1);
        send(8'hE0);
        send(8'h1C, 1'b1);
        send(8'h75);
        expect_evt("par.idle", 1'b0, 1'b0, 8'h75);
        do_clr();

        // Typematic repeats
        send(8'h1C); send(8'h1C); send(8'h1C);
        n = 0;
        for (int i = 0; i < 8 && evt_valid; i++) begin
            evt_ready = 1'b1;
            @(negedge dspclk);
            n++;
        end
        evt_ready = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("typematic.count", n, 1);
`else
        chk("typematic.count", n, 3);
`endif

        // Mid-sequence reset drops prefix and queued events
        send(8'h31); send(8'h32); send(8'hE0);
        reset = 1'b0;
        #1;
        chk("mrst.valid", evt_valid, 1'b0);
        chk("mrst.led", led, 8'h00);
        @(negedge dspclk); reset = 1'b1;
        repeat (3) @(negedge dspclk);
        send(8'h75);
        expect_evt("mrst.mk", 1'b0, 1'b0, 8'h75);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
